// File: rtl/immgen_pipe.sv
// Decode-stage immediate generator with a registered valid/ready output stage.
// An output register plus one skid register let in_ready depend only on the
// stored occupancy, so consumer backpressure never reaches the producer
// combinationally. Each immediate is computed once, at acceptance time.
module immgen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [24:0]      instr,
  input  logic [2:0]       imm_sel,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             imm_err
);

  // Occupancy of the two storage registers.
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t            state, state_next;
  logic [XLEN-1:0]   imm_new;
  logic              err_new;
  logic [31:0]       sext32;
  logic              use_sext;
  logic              in_acc, out_acc;
  logic              load_or, load_sk, move_sk;
  logic [XLEN-1:0]   or_imm, sk_imm;
  logic [TAG_W-1:0]  or_tag, sk_tag;
  logic              or_err, sk_err;

  // instr carries instruction bits [31:7], so instruction bit k is instr[k-7].
  // Sign-extending formats are assembled as a 32-bit value and widened to XLEN.
  always_comb begin
    sext32   = '0;
    use_sext = 1'b1;
    imm_new  = '0;
    err_new  = 1'b0;
    case (imm_sel)
      3'b000: sext32 = {{21{instr[24]}}, instr[23:13]};
      3'b001: sext32 = {{21{instr[24]}}, instr[23:18], instr[4:0]};
      3'b010: sext32 = {{20{instr[24]}}, instr[0], instr[23:18], instr[4:1], 1'b0};
      3'b011,
      3'b101: sext32 = {instr[24:5], 12'b0};
      3'b100: sext32 = {{12{instr[24]}}, instr[12:5], instr[13], instr[23:14], 1'b0};
      3'b111: begin
        use_sext   = 1'b0;
        imm_new[4:0] = instr[17:13];
        if (XLEN == 64) imm_new[5] = instr[18];
      end
      default: begin
        use_sext = 1'b0;
        err_new  = 1'b1;
      end
    endcase
    if (use_sext) begin
      imm_new        = {XLEN{sext32[31]}};
      imm_new[31:0]  = sext32;
    end
  end

  // Ready/valid are decoded purely from the registered occupancy.
  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);

  // Next occupancy and which registers load this cycle; flush overrides everything.
  always_comb begin
    state_next = state;
    load_or    = 1'b0;
    load_sk    = 1'b0;
    move_sk    = 1'b0;
    in_acc     = in_valid && in_ready && !flush;
    out_acc    = out_valid && out_ready;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_acc) begin
            state_next = ONE;
            load_or    = 1'b1;
          end
        end
        ONE: begin
          if (in_acc && out_acc) begin
            load_or = 1'b1;
          end else if (in_acc) begin
            state_next = TWO;
            load_sk    = 1'b1;
          end else if (out_acc) begin
            state_next = EMPTY;
          end
        end
        TWO: begin
          if (out_acc) begin
            state_next = ONE;
            move_sk    = 1'b1;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  // Occupancy register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_next;
  end

  // Output and skid data registers; cleared on reset and flush so no stale data lingers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      or_imm <= '0;
      or_tag <= '0;
      or_err <= 1'b0;
      sk_imm <= '0;
      sk_tag <= '0;
      sk_err <= 1'b0;
    end else if (flush) begin
      or_imm <= '0;
      or_tag <= '0;
      or_err <= 1'b0;
      sk_imm <= '0;
      sk_tag <= '0;
      sk_err <= 1'b0;
    end else begin
      if (move_sk) begin
        or_imm <= sk_imm;
        or_tag <= sk_tag;
        or_err <= sk_err;
      end else if (load_or) begin
        or_imm <= imm_new;
        or_tag <= in_tag;
        or_err <= err_new;
      end
      if (load_sk) begin
        sk_imm <= imm_new;
        sk_tag <= in_tag;
        sk_err <= err_new;
      end
    end
  end

  assign imm     = or_imm;
  assign out_tag = or_tag;
  assign imm_err = or_err;

endmodule
